// File: rtl/mp0_conv1_buf_ctrl_pkg.sv
// Shared types and constants for the maxpool0->conv1 line-buffer controller.
package mp0_conv1_buf_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int N_BANKS    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_e;

endpackage

// File: rtl/mp0_conv1_buf_addr_arb.sv
// Two-requester round-robin arbiter for the shared bank address bus.
// Drives the bank write enables and the shared address from the winning side.
module buf_addr_arb
  import mp0_conv1_buf_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 wr_req,
  input  logic                 rd_req,
  input  logic [1:0]           wr_bank,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [1:0]           grant,
  output logic [N_BANKS-1:0]   wren,
  output logic [ADDR_W-1:0]    addr
);

  // wr_prio_q=0 means the read side wins the next contended cycle.
  logic wr_prio_q, wr_prio_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_prio_q <= 1'b0;
    else        wr_prio_q <= wr_prio_d;
  end

  always_comb begin
    grant     = GNT_NONE;
    wr_prio_d = wr_prio_q;
    if (wr_req && rd_req) begin
      grant     = wr_prio_q ? GNT_WR : GNT_RD;
      wr_prio_d = ~wr_prio_q;
    end else if (wr_req) begin
      grant = GNT_WR;
    end else if (rd_req) begin
      grant = GNT_RD;
    end
    if (clr) wr_prio_d = 1'b0;
  end

  always_comb begin
    wren = '0;
    addr = '0;
    if (grant == GNT_WR) begin
      wren[wr_bank] = 1'b1;
      addr          = wr_addr;
    end else if (grant == GNT_RD) begin
      addr = rd_addr;
    end
  end

endmodule

// File: rtl/mp0_conv1_buf_ctrl.sv
// maxpool0->conv1 line-buffer controller: round-robin row banking plus 3-row window reads.
// Define BUF_CTRL_STALL_CNT_EN to add the stall_cnt port (read-lost-arbitration cycle count).
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | write and read processes active
// DONE    | one-cycle frame_done, then IDLE
module mp0_conv1_buf_ctrl
  import mp0_conv1_buf_ctrl_pkg::*;
#(
  parameter int IMG_W  = 14,
  parameter int IMG_H  = 14,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              wren0,
  output logic              wren1,
  output logic              wren2,
  output logic              wren3,
  output logic [ADDR_W-1:0] wraddr,
  output logic              rd_valid,
  output logic [1:0]        top_bank,
  output logic [ADDR_W-1:0] rd_col,
  output logic              busy,
  output logic              frame_done
`ifdef BUF_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int ROW_W = $clog2(IMG_H + 4);
  localparam logic [ROW_W-1:0]  ROWS        = ROW_W'(IMG_H);
  localparam logic [ROW_W-1:0]  LAST_RD_ROW = ROW_W'(IMG_H - 3);
  localparam logic [ROW_W-1:0]  END_RD_ROW  = ROW_W'(IMG_H - 2);
  localparam logic [ROW_W-1:0]  WIN_ROWS    = ROW_W'(3);
  localparam logic [ADDR_W-1:0] LAST_COL    = ADDR_W'(IMG_W - 1);

  state_e state_q, state_d;
  logic [ROW_W-1:0]  wr_row_q, wr_row_d, rd_row_q, rd_row_d;
  logic [ADDR_W-1:0] wr_col_q, wr_col_d, rd_col_cnt_q, rd_col_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [1:0]        top_bank_q, top_bank_d;
  logic [ADDR_W-1:0] rd_col_q, rd_col_d;

  logic               run, frame_start, wr_req, rd_req;
  logic [1:0]         grant;
  logic [N_BANKS-1:0] wren;

  assign run         = (state_q == ST_RUN);
  assign frame_start = (state_q == ST_IDLE) && start;
  // Row k may overwrite bank k%4 only once output row k-4 has been fully read.
  assign wr_req = run && in_valid && (wr_row_q < ROWS) && (wr_row_q <= rd_row_q + WIN_ROWS);
  assign rd_req = run && out_ready && (rd_row_q <= LAST_RD_ROW) && (wr_row_q >= rd_row_q + WIN_ROWS);

  buf_addr_arb #(.ADDR_W(ADDR_W)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .clr     (frame_start),
    .wr_req  (wr_req),
    .rd_req  (rd_req),
    .wr_bank (wr_row_q[1:0]),
    .wr_addr (wr_col_q),
    .rd_addr (rd_col_cnt_q),
    .grant   (grant),
    .wren    (wren),
    .addr    (wraddr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      rd_row_q     <= '0;
      rd_col_cnt_q <= '0;
      rd_valid_q   <= 1'b0;
      top_bank_q   <= '0;
      rd_col_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      rd_row_q     <= rd_row_d;
      rd_col_cnt_q <= rd_col_cnt_d;
      rd_valid_q   <= rd_valid_d;
      top_bank_q   <= top_bank_d;
      rd_col_q     <= rd_col_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    rd_row_d     = rd_row_q;
    rd_col_cnt_d = rd_col_cnt_q;
    rd_valid_d   = 1'b0;
    top_bank_d   = top_bank_q;
    rd_col_d     = rd_col_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_RUN;
          wr_row_d     = '0;
          wr_col_d     = '0;
          rd_row_d     = '0;
          rd_col_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (grant == GNT_WR) begin
          if (wr_col_q == LAST_COL) begin
            wr_col_d = '0;
            wr_row_d = wr_row_q + 1'b1;
          end else begin
            wr_col_d = wr_col_q + 1'b1;
          end
        end
        // Read data appears on the bank q outputs one cycle after the issue.
        if (grant == GNT_RD) begin
          rd_valid_d = 1'b1;
          top_bank_d = rd_row_q[1:0];
          rd_col_d   = rd_col_cnt_q;
          if (rd_col_cnt_q == LAST_COL) begin
            rd_col_cnt_d = '0;
            rd_row_d     = rd_row_q + 1'b1;
          end else begin
            rd_col_cnt_d = rd_col_cnt_q + 1'b1;
          end
        end
        if (rd_valid_q && (rd_row_q == END_RD_ROW)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready   = (grant == GNT_WR);
  assign wren0      = wren[0];
  assign wren1      = wren[1];
  assign wren2      = wren[2];
  assign wren3      = wren[3];
  assign rd_valid   = rd_valid_q;
  assign top_bank   = top_bank_q;
  assign rd_col     = rd_col_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);

`ifdef BUF_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (frame_start) begin
      stall_cnt_d = '0;
    end else if (rd_req && (grant != GNT_RD) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mp0_conv1_buf_ctrl.sv
// Directed self-checking bench for mp0_conv1_buf_ctrl (14x14 frames).
module tb_mp0_conv1_buf_ctrl;

  localparam int IMG_W  = 14;
  localparam int IMG_H  = 14;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic              wren0, wren1, wren2, wren3;
  logic [ADDR_W-1:0] wraddr;
  logic              rd_valid;
  logic [1:0]        top_bank;
  logic [ADDR_W-1:0] rd_col;
  logic              busy;
  logic              frame_done;
`ifdef BUF_CTRL_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  int n_wr, n_rd, n_done, fc, last_rd_cyc, done_cyc, rd_at_first_wr, exp_stall;
  bit mon_en = 1'b0;
  bit cap_armed = 1'b0;
  bit prev_in_ready = 1'b0;
  bit gw [1024];
  bit rv [1024];

  always #5 clk = ~clk;

  mp0_conv1_buf_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .wren0      (wren0),
    .wren1      (wren1),
    .wren2      (wren2),
    .wren3      (wren3),
    .wraddr     (wraddr),
    .rd_valid   (rd_valid),
    .top_bank   (top_bank),
    .rd_col     (rd_col),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef BUF_CTRL_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: compares every write and read beat against the row/column order of the frame.
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_ready && cap_armed) begin
        rd_at_first_wr = n_rd;
        cap_armed      = 1'b0;
      end
      if (rd_valid) begin
        chk("rd_top_bank", top_bank, (n_rd / IMG_W) % 4);
        chk("rd_col", rd_col, n_rd % IMG_W);
        chk("rd_issued_with_write", prev_in_ready, 0);
        n_rd++;
        last_rd_cyc = fc;
      end
      if (in_ready && out_ready && (n_rd / IMG_W <= IMG_H - 3) &&
          (n_wr / IMG_W >= n_rd / IMG_W + 3))
        exp_stall++;
      if (in_ready) begin
        chk("wr_bank", {wren3, wren2, wren1, wren0}, 1 << ((n_wr / IMG_W) % 4));
        chk("wr_addr", wraddr, n_wr % IMG_W);
        n_wr++;
      end else begin
        chk("wren_without_grant", {wren3, wren2, wren1, wren0}, 0);
      end
      if (frame_done) begin
        n_done++;
        done_cyc = fc;
      end
      if (fc < 1024) begin
        gw[fc] = in_ready;
        rv[fc] = rd_valid;
      end
    end
    prev_in_ready = in_ready;
    fc++;
  end

  task automatic start_frame();
    @(posedge clk); #1;
    start       = 1'b1;
    fc          = 0;
    n_wr        = 0;
    n_rd        = 0;
    n_done      = 0;
    last_rd_cyc = -100;
    done_cyc    = -1;
    exp_stall   = 0;
    for (int i = 0; i < 1024; i++) begin
      gw[i] = 1'b0;
      rv[i] = 1'b0;
    end
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (n_done == 0 && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_done == 0) chk({tag, "_timeout"}, 0, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic frame_checks(input string tag);
    chk({tag, "_writes"}, n_wr, IMG_W * IMG_H);
    chk({tag, "_reads"}, n_rd, (IMG_H - 2) * IMG_W);
    chk({tag, "_done_pulses"}, n_done, 1);
    chk({tag, "_done_after_last_rd"}, done_cyc - last_rd_cyc, 1);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk(tag, {in_ready, wren3, wren2, wren1, wren0, rd_valid, busy, frame_done,
              top_bank, wraddr, rd_col}, 0);
  endtask

  initial begin
    int c;
    int wcnt;
    int k;

    // Reset state
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check_outputs_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("idle_outputs");

    // Full frame with both sides always willing
    start_frame();
    wait_done("s1");
    frame_checks("s1");
`ifdef BUF_CTRL_STALL_CNT_EN
    chk("s1_stall_cnt", stall_cnt, exp_stall);
`endif
    c = -1;
    for (int i = 0; i < 1023; i++)
      if (c < 0 && rv[i+1]) c = i;
    chk("s1_first_rd_grant_cycle", c, 43);
    if (c < 0) c = 0;
    wcnt = 0;
    for (int i = 0; i < c; i++) wcnt += int'(gw[i]);
    chk("s1_writes_before_first_rd", wcnt, 42);
    for (int j = 0; j < 10; j++)
      chk("s1_alternation", {30'd0, gw[c+j], rv[c+j+1]}, (j % 2 == 0) ? 32'd1 : 32'd2);

    // start pulse mid-frame is ignored
    start_frame();
    repeat (50) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("s2");
    frame_checks("s2");

    // Reader stalled: four rows fill, then writes wait for output row 0
    out_ready = 1'b0;
    start_frame();
    repeat (120) @(posedge clk);
    #1;
    chk("s3_writes_while_stalled", n_wr, 56);
    chk("s3_in_ready_blocked", in_ready, 0);
    chk("s3_no_reads", n_rd, 0);
    chk("s3_busy", busy, 1);
    out_ready = 1'b1;
    cap_armed = 1'b1;
    wait_done("s3");
    chk("s3_reads_before_row4_write", rd_at_first_wr, 14);
    frame_checks("s3");

    // Asynchronous reset at write 100, then a fresh frame
    start_frame();
    k = 0;
    while (n_wr < 100 && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("s4_reached_write_100", n_wr, 100);
    #1;
    reset  = 1'b0;
    mon_en = 1'b0;
    #1;
    check_outputs_zero("s4_reset_immediate");
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("s4_reset_held");
    reset = 1'b1;
    start_frame();
    wait_done("s4");
    frame_checks("s4");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
